data_mem_access: RTL and testbench
==================================

Name: data_mem_access

Overview:
- Memory-access stage of the multi-cycle MIPS datapath. Sits between the control FSM/ALU result and the load byte-extraction stage.
- Accepts one load or store request per transaction. Drives a word-aligned data-memory bus with variable wait states.
- For loads, latches the raw returned word, byte offset and load type, which feed the downstream load-extraction logic.
- For stores, generates byte enables and lane-replicated write data. Also detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: cycles waiting for mem_ack before the bus error is raised; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request strobe from control FSM.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  access type; shared encoding: 0 word, 1 half, 2 half-unsigned, 3 byte, 4 byte-unsigned; 5..7 treated as word.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data, right-aligned.
- mem_en  out  1  bus request, held until ack or timeout.
- mem_we  out  1  bus write.
- mem_be  out  4  byte lane enables.
- mem_addr  out  32  word address, {req_addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated write data.
- mem_ack  in  1  bus completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  bus read data.
- mdr_o  out  32  latched raw read word.
- offset_o  out  2  latched req_addr[1:0].
- load_type_o  out  3  latched req_type.
- done  out  1  one-cycle pulse on successful completion.
- misalign  out  1  one-cycle pulse on a rejected misaligned request.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 except req_ready = 1. Any in-flight bus cycle is abandoned: mem_en drops the instant rst asserts.
- States: IDLE, ACCESS.
- IDLE: req_ready = 1, mem_en = 0, and mem_ack is ignored. On req_valid (transfer when valid & ready), the alignment check runs:
  - word: addr[1:0] must be 00;
  - half: addr[0] must be 0;
  - byte: always aligned.
- Misaligned request: on the next cycle misalign = 1 for one cycle and state stays IDLE. No bus cycle is issued, and mdr_o, offset_o and load_type_o are unchanged.
- Aligned request: on the next edge, register mem_addr, mem_we, mem_be, mem_wdata, offset_o and load_type_o, clear the timeout counter, and go to ACCESS.
- ACCESS: mem_en = 1 and req_ready = 0; bus outputs are held stable and req_valid is ignored. The counter increments each cycle without ack.
  - mem_ack = 1: for loads, mdr_o <= mem_rdata; for stores, mdr_o is unchanged. Then done pulses next cycle, mem_en drops, and state returns to IDLE.
  - Counter reaches TIMEOUT_CYCLES without ack: bus_err pulses next cycle, mem_en drops, state returns to IDLE, and mdr_o is unchanged.
  - Ack arriving in the same cycle the counter hits the limit: the ack wins (done, not bus_err).
- Latency: request accepted at edge N. mem_en is high in cycle N+1. With ack in that cycle, done is high and mdr_o is valid in cycle N+2. Each wait state adds one cycle.
- Back-to-back: req_ready returns high in the done cycle, so a new request can be accepted at that edge.
- Load bus signals: mem_be = 1111 and mem_wdata = 0.
- Store bus signals:
  - word: be = 1111, wdata = req_wdata;
  - half: be = 0011 for offset 0, 1100 for offset 2; wdata = {2{req_wdata[15:0]}};
  - byte: be = 0001 << offset; wdata = {4{req_wdata[7:0]}}.
- Signed and unsigned types are identical for stores.
- offset_o and load_type_o hold until the next accepted aligned request.

Decomposition:
- Shared define package: access-type encodings (same values as the load-extraction stage), state encodings, and the default TIMEOUT_CYCLES.
- One natural sub-module: store_lane_gen. It is combinational: type + offset + wdata -> be + replicated wdata. The same sub-module returns 1111 for loads.

Test Plan:
- Load byte at addr 0x1003, mem_rdata = 0xAABBCCDD, ack after 2 wait states:
  - response: mem_addr = 0x1000, be = 1111;
  - response: done 4 cycles after acceptance; mdr_o = 0xAABBCCDD, offset_o = 3, load_type_o = 3.
- Store half 0x00001234 at 0x2002, immediate ack -> be = 1100, wdata = 0x12341234, mem_we = 1, done at N+2, mdr_o unchanged.
- Load word at 0x3001 -> misalign pulse at N+1, mem_en never asserted, req_ready stays 1.
- Load word with no ack, TIMEOUT_CYCLES = 4 -> bus_err pulse after 4 ACCESS cycles, mem_en drops, mdr_o keeps its previous value.
- Assert rst for one cycle mid-ACCESS, then ack arrives -> mem_en low immediately, the late ack is ignored, no done, all outputs 0.
- Two back-to-back store-byte requests (0x10 data 0x5A, then 0x11 data 0xA5), both immediate ack:
  - first: be = 0001, wdata = 0x5A5A5A5A;
  - second: be = 0010, wdata = 0xA5A5A5A5;
  - second accepted on the first's done cycle.

Source files
------------

// File: rtl/data_mem_access_pkg.sv
// Shared definitions for the MIPS data-memory access stage: access-type codes,
// FSM states, default bus timeout and the alignment helpers used on request entry.
package data_mem_access_pkg;

    // Same codes as the load-extraction stage; 5..7 behave as word accesses.
    typedef enum logic [2:0] {
        ACC_WORD   = 3'd0,
        ACC_HALF   = 3'd1,
        ACC_HALF_U = 3'd2,
        ACC_BYTE   = 3'd3,
        ACC_BYTE_U = 3'd4
    } access_type_e;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } access_size_e;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // Signedness only matters to the load extractor, so collapse to a size.
    function automatic access_size_e access_size(input logic [2:0] req_type);
        case (req_type)
            ACC_HALF, ACC_HALF_U: return SZ_HALF;
            ACC_BYTE, ACC_BYTE_U: return SZ_BYTE;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input access_size_e size, input logic [1:0] offset);
        case (size)
            SZ_WORD: return offset == 2'b00;
            SZ_HALF: return !offset[0];
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_access_store_lane_gen.sv
// Combinational byte-lane generator: turns access type, offset and right-aligned
// store data into bus byte enables and lane-replicated write data.
module data_mem_access_store_lane_gen
    import data_mem_access_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  req_type,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata
);

    // Loads read the full word; the extractor picks the bytes it needs later.
    always_comb begin
        be         = 4'b1111;
        lane_wdata = '0;
        if (we) begin
            case (access_size(req_type))
                SZ_HALF: begin
                    be         = offset[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{wdata[15:0]}};
                end
                SZ_BYTE: begin
                    be         = 4'b0001 << offset;
                    lane_wdata = {4{wdata[7:0]}};
                end
                default: begin
                    be         = 4'b1111;
                    lane_wdata = wdata;
                end
            endcase
        end
    end

endmodule

// File: rtl/data_mem_access.sv
// Memory-access stage of the multi-cycle MIPS datapath: issues one word-aligned
// bus cycle per request, latches load data and flags misalignment or timeout.
module data_mem_access
    import data_mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mdr_o,
    output logic [1:0]  offset_o,
    output logic [2:0]  load_type_o,
    output logic        done,
    output logic        misalign,
    output logic        bus_err
);

    // Counter value seen in the final ACCESS cycle before giving up.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_e      state;
    logic [7:0]  wait_cnt;
    logic        req_aligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    assign req_aligned = is_aligned(access_size(req_type), req_addr[1:0]);

    data_mem_access_store_lane_gen u_lanes (
        .we         (req_we),
        .req_type   (req_type),
        .offset     (req_addr[1:0]),
        .wdata      (req_wdata),
        .be         (lane_be),
        .lane_wdata (lane_wdata)
    );

    // An ack in the limit cycle is checked first, so it beats the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b1;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mdr_o       <= '0;
            offset_o    <= '0;
            load_type_o <= '0;
            done        <= 1'b0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_aligned) begin
                            state       <= ST_ACCESS;
                            req_ready   <= 1'b0;
                            mem_en      <= 1'b1;
                            mem_we      <= req_we;
                            mem_be      <= lane_be;
                            mem_addr    <= {req_addr[31:2], 2'b00};
                            mem_wdata   <= lane_wdata;
                            offset_o    <= req_addr[1:0];
                            load_type_o <= req_type;
                            wait_cnt    <= '0;
                        end else begin
                            misalign <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            mdr_o <= mem_rdata;
                        end
                        done      <= 1'b1;
                        mem_en    <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        bus_err   <= 1'b1;
                        mem_en    <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_en    <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access.sv
// Self-checking bench for data_mem_access: a transaction-level timeline model
// predicts every output each cycle; directed cases pin the model with literals.
module tb_data_mem_access;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_type = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mdr_o;
    logic [1:0]  offset_o;
    logic [2:0]  load_type_o;
    logic        done;
    logic        misalign;
    logic        bus_err;

    data_mem_access #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_type    (req_type),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mdr_o       (mdr_o),
        .offset_o    (offset_o),
        .load_type_o (load_type_o),
        .done        (done),
        .misalign    (misalign),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checkCount = 0;
    int errorCount = 0;

    logic        expReady, expEn, expWe, expDone, expMis, expErr;
    logic [3:0]  expBe;
    logic [31:0] expAddr, expWdata, expMdr;
    logic [1:0]  expOff;
    logic [2:0]  expType;
    bit          modelOn = 1'b0;

    logic [31:0] seenAddr, seenWdata;
    logic [3:0]  seenBe;
    logic        seenWe;
    int          enCycles = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // Single compare process: model expectations checked on every falling edge.
    always @(negedge clk) begin
        if (modelOn) begin
            checkOutput("req_ready",   32'(req_ready),   32'(expReady));
            checkOutput("mem_en",      32'(mem_en),      32'(expEn));
            checkOutput("done",        32'(done),        32'(expDone));
            checkOutput("misalign",    32'(misalign),    32'(expMis));
            checkOutput("bus_err",     32'(bus_err),     32'(expErr));
            checkOutput("mdr_o",       mdr_o,            expMdr);
            checkOutput("offset_o",    32'(offset_o),    32'(expOff));
            checkOutput("load_type_o", 32'(load_type_o), 32'(expType));
            if (expEn) begin
                checkOutput("mem_we",    32'(mem_we), 32'(expWe));
                checkOutput("mem_be",    32'(mem_be), 32'(expBe));
                checkOutput("mem_addr",  mem_addr,    expAddr);
                checkOutput("mem_wdata", mem_wdata,   expWdata);
            end
        end
        if (mem_en) begin
            seenAddr  <= mem_addr;
            seenWdata <= mem_wdata;
            seenBe    <= mem_be;
            seenWe    <= mem_we;
            enCycles  <= enCycles + 1;
        end
    end

    function automatic int accSize(input logic [2:0] t);
        if (t == 3'd1 || t == 3'd2) return 2;
        if (t == 3'd3 || t == 3'd4) return 1;
        return 4;
    endfunction

    function automatic logic [3:0] modelBe(input logic we, input logic [2:0] t, input logic [31:0] addr);
        int sz = accSize(t);
        int off = int'(addr[1:0]);
        logic [3:0] be = '0;
        if (!we) return 4'hF;
        for (int j = 0; j < 4; j++)
            if (j >= off && j < off + sz) be[j] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] modelWdata(input logic we, input logic [2:0] t, input logic [31:0] d);
        int sz = accSize(t);
        logic [31:0] w = '0;
        if (!we) return '0;
        for (int j = 0; j < 4; j++)
            w[8*j +: 8] = d[8*(j % sz) +: 8];
        return w;
    endfunction

    task automatic setIdle();
        expReady = 1'b1;
        expEn    = 1'b0;
        expDone  = 1'b0;
        expMis   = 1'b0;
        expErr   = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            req_valid = 1'b0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom();
            nextCycle();
            setIdle();
        end
        mem_ack = 1'b0;
    endtask

    // Runs one request; returns in the done/bus_err/misalign cycle with the DUT idle.
    task automatic applyStimulus(input logic we, input logic [2:0] t, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int ackDelay, output int reqCyc);
        reqCyc    = cyc;
        req_valid = 1'b1;
        req_we    = we;
        req_type  = t;
        req_addr  = addr;
        req_wdata = wdata;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
        nextCycle();
        if ((int'(addr[1:0]) % accSize(t)) != 0) begin
            req_valid = 1'b0;
            mem_ack   = 1'b0;
            setIdle();
            expMis = 1'b1;
            return;
        end
        expOff   = addr[1:0];
        expType  = t;
        expAddr  = {addr[31:2], 2'b00};
        expWe    = we;
        expBe    = modelBe(we, t, addr);
        expWdata = modelWdata(we, t, wdata);
        for (int i = 0; i < 300; i++) begin
            expReady  = 1'b0;
            expEn     = 1'b1;
            expDone   = 1'b0;
            expMis    = 1'b0;
            expErr    = 1'b0;
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = $urandom();
            req_type  = 3'($urandom_range(0, 7));
            mem_ack   = (i == ackDelay);
            mem_rdata = (i == ackDelay) ? rdata : $urandom();
            nextCycle();
            if (i == ackDelay) begin
                setIdle();
                expDone = 1'b1;
                if (!we) expMdr = rdata;
                break;
            end
            if (i == TIMEOUT - 1) begin
                setIdle();
                expErr = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        mem_ack   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r, r2, enBefore, doneCyc1, d, sel;
        logic [3:0]  be1;
        logic [31:0] wd1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset mem_en",    32'(mem_en),    32'd0);
        checkOutput("reset done",      32'(done),      32'd0);
        checkOutput("reset mdr_o",     mdr_o,          32'd0);
        checkOutput("reset mem_be",    32'(mem_be),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expMdr = '0; expOff = '0; expType = '0; expWe = 1'b0;
        expBe = '0; expAddr = '0; expWdata = '0;
        setIdle();
        modelOn = 1'b1;
        idleCycles(2);

        // Load byte at 0x1003, two wait states.
        applyStimulus(1'b0, 3'd3, 32'h0000_1003, 32'h0, 32'hAABB_CCDD, 2, r);
        @(negedge clk);
        checkOutput("lb mem_addr",    seenAddr,            32'h0000_1000);
        checkOutput("lb mem_be",      32'(seenBe),         32'hF);
        checkOutput("lb done",        32'(done),           32'd1);
        checkOutput("lb latency",     32'(cyc - r),        32'd4);
        checkOutput("lb mdr_o",       mdr_o,               32'hAABB_CCDD);
        checkOutput("lb offset_o",    32'(offset_o),       32'd3);
        checkOutput("lb load_type_o", 32'(load_type_o),    32'd3);
        idleCycles(1);

        // Store half at 0x2002, immediate ack.
        applyStimulus(1'b1, 3'd1, 32'h0000_2002, 32'h0000_1234, 32'h5555_5555, 0, r);
        @(negedge clk);
        checkOutput("sh mem_be",    32'(seenBe),  32'hC);
        checkOutput("sh mem_wdata", seenWdata,    32'h1234_1234);
        checkOutput("sh mem_we",    32'(seenWe),  32'd1);
        checkOutput("sh latency",   32'(cyc - r), 32'd2);
        checkOutput("sh mdr_o",     mdr_o,        32'hAABB_CCDD);
        idleCycles(1);

        // Misaligned load word.
        enBefore = enCycles;
        applyStimulus(1'b0, 3'd0, 32'h0000_3001, 32'h0, 32'h0, 0, r);
        @(negedge clk);
        checkOutput("mis pulse",     32'(misalign),          32'd1);
        checkOutput("mis latency",   32'(cyc - r),           32'd1);
        checkOutput("mis req_ready", 32'(req_ready),         32'd1);
        checkOutput("mis no bus",    32'(enCycles - enBefore), 32'd0);
        idleCycles(1);

        // Timeout: never acked.
        enBefore = enCycles;
        applyStimulus(1'b0, 3'd0, 32'h0000_4000, 32'h0, 32'h0, 1000, r);
        @(negedge clk);
        checkOutput("to bus_err",   32'(bus_err),             32'd1);
        checkOutput("to en cycles", 32'(enCycles - enBefore), 32'd4);
        checkOutput("to mem_en",    32'(mem_en),              32'd0);
        checkOutput("to mdr_o",     mdr_o,                    32'hAABB_CCDD);
        idleCycles(1);

        // Ack in the limit cycle wins over the timeout.
        applyStimulus(1'b0, 3'd0, 32'h0000_5000, 32'h0, 32'h0BAD_F00D, TIMEOUT - 1, r);
        @(negedge clk);
        checkOutput("lim done",    32'(done),    32'd1);
        checkOutput("lim bus_err", 32'(bus_err), 32'd0);
        checkOutput("lim mdr_o",   mdr_o,        32'h0BAD_F00D);
        idleCycles(1);

        // Back-to-back store bytes.
        applyStimulus(1'b1, 3'd3, 32'h0000_0010, 32'h0000_005A, 32'h0, 0, r);
        be1 = seenBe;
        wd1 = seenWdata;
        doneCyc1 = cyc;
        applyStimulus(1'b1, 3'd4, 32'h0000_0011, 32'h0000_00A5, 32'h0, 0, r2);
        @(negedge clk);
        checkOutput("sb1 mem_be",    32'(be1),          32'h1);
        checkOutput("sb1 mem_wdata", wd1,               32'h5A5A_5A5A);
        checkOutput("sb2 mem_be",    32'(seenBe),       32'h2);
        checkOutput("sb2 mem_wdata", seenWdata,         32'hA5A5_A5A5);
        checkOutput("sb2 done",      32'(done),         32'd1);
        checkOutput("sb2 latency",   32'(cyc - doneCyc1), 32'd2);
        idleCycles(2);

        // Reset in the middle of an ACCESS, late ack ignored.
        req_valid = 1'b1; req_we = 1'b0; req_type = 3'd0; req_addr = 32'h0000_0040;
        nextCycle();
        req_valid = 1'b0;
        expReady = 1'b0; expEn = 1'b1; expWe = 1'b0; expBe = 4'hF;
        expAddr = 32'h0000_0040; expWdata = '0; expOff = 2'd0; expType = 3'd0;
        @(negedge clk);
        #1;
        modelOn = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst mem_en now",    32'(mem_en),    32'd0);
        checkOutput("rst req_ready now", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        nextCycle();
        mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("rst late done", 32'(done),      32'd0);
        checkOutput("rst mdr_o",     mdr_o,          32'd0);
        checkOutput("rst mem_en",    32'(mem_en),    32'd0);
        checkOutput("rst mem_addr",  mem_addr,       32'd0);
        checkOutput("rst mem_be",    32'(mem_be),    32'd0);
        checkOutput("rst mem_wdata", mem_wdata,      32'd0);
        checkOutput("rst mem_we",    32'(mem_we),    32'd0);
        checkOutput("rst bus_err",   32'(bus_err),   32'd0);
        checkOutput("rst misalign",  32'(misalign),  32'd0);
        checkOutput("rst req_ready", 32'(req_ready), 32'd1);
        expMdr = '0; expOff = '0; expType = '0;
        setIdle();
        modelOn = 1'b1;
        idleCycles(1);

        // Randomized traffic against the timeline model.
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)       d = $urandom_range(0, 2);
            else if (sel == 6) d = TIMEOUT - 1;
            else if (sel == 7) d = 1000;
            else               d = $urandom_range(0, TIMEOUT - 1);
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                          $urandom(), $urandom(), d, r);
            idleCycles($urandom_range(0, 2));
        end
        idleCycles(3);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
